// File: rtl/jtag_master.sv
// jtag_master: parametrised JTAG TAP master.
//
// Drives TCK/TMS/TDI and captures TDO for four operations: IR scan, DR scan,
// TAP reset and Run-Test/Idle clocking. Every completed operation leaves the
// TAP parked in Run-Test/Idle. TCK is derived from clk: each TCK cycle is DIV
// clk cycles low followed by DIV clk cycles high.
//
// Ports:
//   clk    system clock (only clock in the block)
//   rst    asynchronous active-low reset
//   start  one-cycle command strobe, accepted only while idle
//   op     00 IR scan, 01 DR scan, 10 TAP reset, 11 idle clocks
//   len    scan length (00/01) or TCK count (11)
//   wdata  TDI data, shifted out LSB first
//   busy   operation in progress
//   done   one-cycle completion pulse
//   err    one-cycle pulse when a scan command is rejected
//   rdata  captured TDO, bit i sampled in shift cycle i
//   tck    JTAG clock
//   tms    JTAG mode select
//   tdi    JTAG data to the target
//   tdo    JTAG data from the target
module jtag_master #(
  parameter int SHIFT_W = 32,
  parameter int LEN_W   = 16,
  parameter int DIV     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [LEN_W-1:0]   len,
  input  logic [SHIFT_W-1:0] wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SHIFT_W-1:0] rdata,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    OP_IR    = 2'b00,
    OP_DR    = 2'b01,
    OP_RESET = 2'b10,
    OP_IDLE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e             state;
  op_e                op_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   total_q;   // TCK cycles in the latched operation
  logic [LEN_W-1:0]   tck_idx;   // index of the TCK cycle currently on the pins
  logic [DIV_W-1:0]   div_cnt;
  logic               primed;    // first RUN cycle has driven the pins
  logic               reject_q;
  logic [SHIFT_W-1:0] wdata_q;   // shifts right; bit 0 is the next TDI bit
  logic [SHIFT_W-1:0] cap_mask;  // one-hot position of the next captured bit

  logic [1:0]         step_cur;  // {shift, tms} of the current TCK cycle
  logic [1:0]         step_nxt;  // {shift, tms} of the next TCK cycle
  logic [LEN_W-1:0]   nxt_idx;
  logic [SHIFT_W-1:0] wdata_adv;
  logic [LEN_W-1:0]   total_in;
  logic               scan_in;
  logic               bad_len;

  // TMS value and shift flag for TCK cycle i of an operation.
  function automatic logic [1:0] step_at(op_e o, logic [LEN_W-1:0] n,
                                         logic [LEN_W-1:0] i);
    logic [LEN_W-1:0] pre;
    logic             shift;
    logic             t;
    shift = 1'b0;
    t     = 1'b0;
    pre   = (o == OP_IR) ? LEN_W'(4) : LEN_W'(3);
    case (o)
      OP_IR, OP_DR: begin
        if (i < pre) begin
          // IR entry is 1,1,0,0; DR entry is 1,0,0.
          t = (o == OP_IR) ? (i < LEN_W'(2)) : (i == '0);
        end else if (i < pre + n) begin
          shift = 1'b1;
          t     = (i == pre + n - LEN_W'(1));  // last shift exits to Exit1
        end else begin
          t = (i == pre + n);                  // Update, then Run-Test/Idle
        end
      end
      OP_RESET: t = (i < LEN_W'(5));
      default:  t = 1'b0;
    endcase
    return {shift, t};
  endfunction

  // NOTE: every signal in this block is assigned on every path, so no latch
  // is inferred.
  always_comb begin
    step_cur  = primed ? step_at(op_q, len_q, tck_idx) : 2'b00;
    nxt_idx   = primed ? tck_idx + LEN_W'(1) : '0;
    step_nxt  = step_at(op_q, len_q, nxt_idx);
    wdata_adv = step_cur[1] ? (wdata_q >> 1) : wdata_q;
    scan_in   = (op[1] == 1'b0);
    bad_len   = (len == '0) || (len > LEN_W'(SHIFT_W));
    case (op)
      2'b00:   total_in = len + LEN_W'(6);
      2'b01:   total_in = len + LEN_W'(5);
      2'b10:   total_in = LEN_W'(6);
      default: total_in = len;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_q     <= OP_IR;
      len_q    <= '0;
      total_q  <= '0;
      tck_idx  <= '0;
      div_cnt  <= '0;
      primed   <= 1'b0;
      reject_q <= 1'b0;
      wdata_q  <= '0;
      cap_mask <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      tck      <= 1'b0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= op_e'(op);
            len_q    <= len;
            total_q  <= total_in;
            wdata_q  <= wdata;
            tck_idx  <= '0;
            div_cnt  <= '0;
            primed   <= 1'b0;
            reject_q <= 1'b0;
            if (scan_in && bad_len) begin
              reject_q <= 1'b1;
              state    <= S_FINISH;
            end else if (!scan_in && op[0] && len == '0) begin
              state <= S_FINISH;  // zero idle clocks: just acknowledge
            end else begin
              state <= S_RUN;
              if (scan_in) begin
                rdata    <= '0;
                cap_mask <= SHIFT_W'(1);
              end
            end
          end
        end

        S_FINISH: begin
          err   <= reject_q;
          done  <= !reject_q;
          state <= S_IDLE;
        end

        S_RUN: begin
          if (!primed) begin
            // Put TCK cycle 0 on the pins; its low half starts now.
            primed <= 1'b1;
            busy   <= 1'b1;
            tck    <= 1'b0;
            tms    <= step_nxt[0];
            tdi    <= step_nxt[1] & wdata_q[0];
          end else if (div_cnt != DIV_W'(DIV - 1)) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!tck) begin
              tck <= 1'b1;
              if (step_cur[1] && tdo) begin
                rdata <= rdata | cap_mask;
              end
            end else begin
              tck <= 1'b0;
              if (step_cur[1]) begin
                cap_mask <= cap_mask << 1;
              end
              if (tck_idx == total_q - LEN_W'(1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                tms   <= 1'b0;
                tdi   <= 1'b0;
                state <= S_IDLE;
              end else begin
                tck_idx <= nxt_idx;
                tms     <= step_nxt[0];
                tdi     <= step_nxt[1] & wdata_adv[0];
                wdata_q <= wdata_adv;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: self-checking bench for jtag_master (DIV=2).
// Directed vector table, hand-written corner sequences and a randomized loop,
// all compared against a list-based model of the TMS/TDI/TDO rules.
module tb_jtag_master;

  localparam int SHIFT_W = 32;
  localparam int LEN_W   = 16;
  localparam int DIV     = 2;
  localparam int HIST    = 8192;

  localparam int M_TOGGLE = 0;
  localparam int M_LOOP   = 1;
  localparam int M_RAND   = 2;
  localparam int M_ONE    = 3;

  logic               clk   = 1'b0;
  logic               rst   = 1'b1;
  logic               start = 1'b0;
  logic [1:0]         op    = 2'b00;
  logic [LEN_W-1:0]   len   = '0;
  logic [SHIFT_W-1:0] wdata = '0;
  logic               busy, done, err, tck, tms, tdi, tdo;
  logic [SHIFT_W-1:0] rdata;

  int   tdo_mode = M_TOGGLE;
  logic tdo_r    = 1'b0;
  assign tdo = (tdo_mode == M_LOOP) ? tdi : tdo_r;

  always #5 clk = ~clk;

  jtag_master #(.SHIFT_W(SHIFT_W), .LEN_W(LEN_W), .DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .len   (len),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .tck   (tck),
    .tms   (tms),
    .tdi   (tdi),
    .tdo   (tdo)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Global edge counter and the tdo value seen at every rising clk edge.
  int   cyc_g = 0;
  logic tdo_hist [HIST];
  always @(posedge clk) begin
    cyc_g <= cyc_g + 1;
    tdo_hist[(cyc_g + 1) % HIST] <= tdo;
  end

  // tdo stimulus changes only on falling clk edges.
  int tdiv = 0;
  always @(negedge clk) begin
    tdiv <= tdiv + 1;
    if (tdo_mode == M_TOGGLE && (tdiv % 10) == 9) tdo_r <= ~tdo_r;
    else if (tdo_mode == M_RAND)                  tdo_r <= 1'($urandom);
    else if (tdo_mode == M_ONE)                   tdo_r <= 1'b1;
  end

  // Pin monitor: one record per TCK cycle, taken just after tck rises.
  logic tck_prev = 1'b0;
  bit   tms_q[$];
  bit   tdi_q[$];
  int   rise_q[$];
  int   stab_err = 0;
  always @(negedge clk) begin
    if (tck && !tck_prev) begin
      tms_q.push_back(tms);
      tdi_q.push_back(tdi);
      rise_q.push_back(cyc_g);
    end else if (tck && tck_prev && (tms !== tms_q[$] || tdi !== tdi_q[$])) begin
      stab_err <= stab_err + 1;
    end
    tck_prev <= tck;
  end

  // ---------------- reference model ----------------
  function automatic int model_ntck(logic [1:0] o, int l);
    case (o)
      2'b00:   return l + 6;
      2'b01:   return l + 5;
      2'b10:   return 6;
      default: return l;
    endcase
  endfunction

  function automatic int model_pre(logic [1:0] o);
    return (o == 2'b00) ? 4 : 3;
  endfunction

  function automatic logic [127:0] model_tms(logic [1:0] o, int l);
    bit q[$];
    logic [127:0] v;
    if (o == 2'b00) for (int i = 0; i < 4; i++) q.push_back(i < 2);
    if (o == 2'b01) for (int i = 0; i < 3; i++) q.push_back(i == 0);
    if (o < 2) begin
      for (int i = 0; i < l; i++) q.push_back(i == l - 1);
      q.push_back(1'b1);
      q.push_back(1'b0);
    end
    if (o == 2'b10) for (int i = 0; i < 6; i++) q.push_back(i < 5);
    if (o == 2'b11) for (int i = 0; i < l; i++) q.push_back(1'b0);
    v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  function automatic logic [127:0] model_tdi(logic [1:0] o, int l,
                                             logic [31:0] w);
    logic [127:0] v;
    v = '0;
    if (o < 2) for (int i = 0; i < l; i++) v[model_pre(o) + i] = w[i];
    return v;
  endfunction

  logic [31:0] model_rd = '0;

  // Issues one command and checks everything about it. Returns at the
  // falling edge after the done/err pulse (or after the bound expires).
  task automatic run_op(input logic [1:0] o, input int l, input logic [31:0] w,
                        input int intrude_at, output int got_cyc);
    int n, pre, lim, c, t0, bad, stab0;
    bit is_scan, rej, zid, busy_gap, busy1, tck1, tms1, tck_any, act_any;
    logic [127:0] exp_t, got_t, got_d;
    logic [31:0] exp_rd;
    is_scan = (o < 2);
    rej     = is_scan && (l == 0 || l > SHIFT_W);
    zid     = (o == 2'b11) && (l == 0);
    n       = model_ntck(o, l);
    pre     = model_pre(o);
    exp_t   = model_tms(o, l);
    tms_q.delete();
    tdi_q.delete();
    rise_q.delete();
    stab0 = stab_err;
    op    = o;
    len   = LEN_W'(l);
    wdata = w;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    t0    = cyc_g;
    lim   = (rej || zid) ? 4 : 2 * DIV * n + 20;
    c = 0; busy_gap = 0; busy1 = 0; tck1 = 0; tms1 = 0;
    while (c < lim && !(done || err)) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      start = (intrude_at > 0 && c == intrude_at);
      if (start) begin
        op    = 2'b10;
        len   = LEN_W'(7);
        wdata = ~w;
      end
      if (c == 1) begin busy1 = busy; tck1 = tck; tms1 = tms; end
      if (!rej && !zid && !done && !err && !busy) busy_gap = 1;
    end
    start   = 1'b0;
    got_cyc = c;
    check("done_cycle", c, (rej || zid) ? 1 : 1 + 2 * DIV * n);
    check("pulse_err_done", {err, done}, rej ? 2'b10 : 2'b01);
    if (rej || zid) begin
      tck_any = 0; act_any = 0;
      for (int k = 0; k < 2 * DIV + 2; k++) begin
        @(posedge clk);
        @(negedge clk);
        tck_any |= tck;
        act_any |= busy | done | err;
      end
      check("no_tck_activity", {tck_any, act_any}, 2'b00);
    end else begin
      check("first_cycle", {busy1, tck1, tms1}, {1'b1, 1'b0, exp_t[0]});
      check("busy_held", busy_gap, 0);
      check("end_pins", {busy, tck, tms, tdi}, 4'b0000);
      check("tck_count", tms_q.size(), n);
      got_t = '0;
      got_d = '0;
      foreach (tms_q[i]) got_t[i] = tms_q[i];
      foreach (tdi_q[i]) got_d[i] = tdi_q[i];
      check("tms_seq", got_t, exp_t);
      check("tdi_seq", got_d, model_tdi(o, l, w));
      bad = 0;
      foreach (rise_q[k]) if (rise_q[k] != t0 + 1 + DIV + 2 * DIV * k) bad++;
      check("tck_rise_timing", bad, 0);
      check("pins_stable_high", stab_err - stab0, 0);
      if (is_scan) begin
        exp_rd = '0;
        for (int i = 0; i < l; i++)
          exp_rd[i] = tdo_hist[(t0 + 1 + DIV + 2 * DIV * (pre + i)) % HIST];
        model_rd = exp_rd;
      end
    end
    check("rdata", rdata, model_rd);
  endtask

  typedef struct {
    logic [1:0]  op;
    int          len;
    logic [31:0] wdata;
    int          mode;
    int          exp_cyc;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int c, prev_done, o, l, r;
    bit done_seen;

    vecs[0] = '{2'b10, 0,  32'h0,          M_TOGGLE, 25,  1'b0, 32'h0};
    vecs[1] = '{2'b00, 10, 32'h0000019C,   M_TOGGLE, 65,  1'b0, 32'h0};
    vecs[2] = '{2'b01, 32, 32'hDEADBEEF,   M_LOOP,   149, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{2'b01, 0,  32'h12345678,   M_RAND,   1,   1'b1, 32'hDEADBEEF};
    vecs[4] = '{2'b00, 33, 32'h87654321,   M_RAND,   1,   1'b1, 32'hDEADBEEF};
    vecs[5] = '{2'b11, 0,  32'h0,          M_RAND,   1,   1'b1, 32'hDEADBEEF};
    vecs[6] = '{2'b11, 5,  32'hFFFFFFFF,   M_RAND,   21,  1'b1, 32'hDEADBEEF};

    // Power-on reset.
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", {tck, tms, tdi, busy, done, err}, 6'b010000);
    check("reset_rdata", rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("tms_high_after_reset", tms, 1'b1);

    // Directed vectors (back-to-back: each start lands on the done cycle).
    for (int i = 0; i < 7; i++) begin
      tdo_mode = vecs[i].mode;
      run_op(vecs[i].op, vecs[i].len, vecs[i].wdata, 0, c);
      check("vec_cycle", c, vecs[i].exp_cyc);
      if (vecs[i].chk_rd) check("vec_rdata", rdata, vecs[i].exp_rd);
    end

    // start with op=10 during a DR scan must be ignored.
    tdo_mode = M_RAND;
    run_op(2'b01, 20, 32'hA5C3_0F96, 30, c);

    // Start on the done cycle: next op begins with no idle TCK cycle.
    prev_done = cyc_g;
    run_op(2'b00, 7, 32'h0000_0055, 0, c);
    check("b2b_gap", rise_q[0] - prev_done, 2 + DIV);

    // Asynchronous reset in the middle of a scan.
    tdo_mode = M_ONE;
    repeat (2) @(negedge clk);
    op = 2'b01; len = LEN_W'(32); wdata = 32'h1357_9BDF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("busy_before_reset", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("async_reset_pins", {tck, tms, tdi, busy, done, err}, 6'b010000);
    check("async_reset_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_rd  = '0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      done_seen |= done | busy | tck;
    end
    check("no_done_after_abort", done_seen, 1'b0);
    tdo_mode = M_TOGGLE;
    run_op(2'b10, 0, 32'h0, 0, c);
    check("reset_op_cycle", c, 25);

    // Randomized commands against the model.
    tdo_mode = M_RAND;
    for (int k = 0; k < 14; k++) begin
      o = int'($urandom_range(0, 3));
      if (o < 2) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) l = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 40));
        else        l = int'($urandom_range(1, 32));
      end else begin
        l = int'($urandom_range(0, 30));
      end
      run_op(2'(o), l, $urandom, 0, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
